adder_64_seq: RTL and testbench

Multi-cycle, segmented 64-bit adder with valid/ready handshakes on both sides. It accepts one operand pair plus carry-in, sums it one SEG_W-bit slice per clock through a registered carry, then holds `sum`/`cout` until the consumer takes them. It is the registered operand-issue/result-capture stage used wherever the flat combinational 64-bit ripple adder cannot meet timing. It is bit-exact with that adder: `{cout,sum} = in1 + in2 + cin`.

---
 rtl/adder_64_seq_if.sv | 34 +++
 rtl/adder_64_seq.sv | 147 ++++++++++++++
 tb/tb_adder_64_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_64_seq_if.sv
// rtl/adder_64_seq_if.sv - operand-issue / result-capture bus for adder_64_seq
//
// Signals:
//   in_valid   operand pair presented (master -> slave)
//   in_ready   slave can accept operands this cycle (slave -> master)
//   in1, in2   64-bit operands (master -> slave)
//   cin        carry-in (master -> slave)
//   out_valid  sum/cout hold a completed result (slave -> master)
//   out_ready  consumer accepts the result (master -> slave)
//   sum        64-bit registered result (slave -> master)
//   cout       registered carry-out of bit 63 (slave -> master)
//   busy       slave is summing slices (slave -> master)
interface adder_64_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in1;
  logic [63:0] in2;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        busy;

  modport master (
    output in_valid, in1, in2, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, in1, in2, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/adder_64_seq.sv
// rtl/adder_64_seq.sv - multi-cycle segmented 64-bit adder, {cout,sum} = in1 + in2 + cin
//
// Parameters:
//   SEG_W      slice width summed per cycle (8, 16, 32 or 64)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        adder_64_seq_if.slave: in_valid/in_ready/in1/in2/cin operand side,
//              out_valid/out_ready/sum/cout result side, busy while summing
module adder_64_seq #(
  parameter int SEG_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  adder_64_seq_if.slave  bus
);

  localparam int NSEG  = 64 / SEG_W;
  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int SUM_W = SEG_W + 1;

  generate
    if (SEG_W != 8 && SEG_W != 16 && SEG_W != 32 && SEG_W != 64) begin : g_bad_seg_w
      $error("adder_64_seq: SEG_W must be 8, 16, 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        a_q, a_d;
  logic [63:0]        b_q, b_d;
  logic               c_q, c_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [63:0]        sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               in_ready_c;
  logic               load;
  logic               last_seg;
  logic [SEG_W-1:0]   seg_a;
  logic [SEG_W-1:0]   seg_b;
  logic [SUM_W-1:0]   seg_sum;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready_c = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign load       = bus.in_valid && in_ready_c;
  assign last_seg   = (idx_q == IDX_W'(NSEG - 1));

  // Slice select by comparing idx against each constant segment position,
  // which keeps every part-select index static.
  always_comb begin
    seg_a = '0;
    seg_b = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        seg_a = a_q[i*SEG_W +: SEG_W];
        seg_b = b_q[i*SEG_W +: SEG_W];
      end
    end
  end

  // The only carry path between slices is c_q.
  assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + SUM_W'(c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end

      S_CALC: begin
        for (int i = 0; i < NSEG; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
          end
        end
        c_d = seg_sum[SEG_W];
        if (last_seg) begin
          cout_d  = seg_sum[SEG_W];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An accept in IDLE, or in DONE together with the consumer handshake,
    // starts the next operation immediately.
    if (load) begin
      a_d     = bus.in1;
      b_d     = bus.in2;
      c_d     = bus.cin;
      idx_d   = '0;
      state_d = S_CALC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_CALC);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_adder_64_seq.sv
// tb/tb_adder_64_seq.sv - directed bench for adder_64_seq at SEG_W = 8, 16, 32, 64
module tb_adder_64_seq;

  localparam int SW [4]  = '{8, 16, 32, 64};
  localparam int LAT [4] = '{8, 4, 2, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir   [4];
  logic        ov   [4];
  logic        bsy  [4];
  logic [63:0] sm   [4];
  logic        co   [4];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    adder_64_seq_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in1       = in1;
    assign bus.in2       = in2;
    assign bus.cin       = cin;
    assign bus.out_ready = out_ready;
    assign ir[g]  = bus.in_ready;
    assign ov[g]  = bus.out_valid;
    assign bsy[g] = bus.busy;
    assign sm[g]  = bus.sum;
    assign co[g]  = bus.cout;

    adder_64_seq #(.SEG_W(SW[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair to every instance; returns at the first
  // falling edge after the accept edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic c);
    @(negedge clk);
    in1 = a;
    in2 = b;
    cin = c;
    in_valid = 1'b1;
    chk("accept_in_ready", 64'(ir[1]), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for the SEG_W=16 result, checks latency and value, then consumes it.
  task automatic wait_done16(input string tag, input logic [63:0] es, input logic ec);
    int cnt;
    cnt = 0;
    while (!ov[1] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, 64'(cnt), 64'd4);
    chk({tag, "_sum"}, sm[1], es);
    chk({tag, "_cout"}, 64'(co[1]), 64'(ec));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_consumed"}, 64'(ov[1]), 64'd0);
  endtask

  initial begin
    logic [63:0] hold_sum;
    logic        hold_cout;
    logic        seen;
    int          lat [4];
    logic [63:0] rs  [4];
    logic        rc  [4];
    int          p16 [3];
    int          p64 [3];
    int          n16, n64;
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic        vc [4];
    logic [63:0] vs [4];
    logic        vo [4];

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ir[1]), 64'd1);
    chk("rst_out_valid", 64'(ov[1]), 64'd0);
    chk("rst_busy", 64'(bsy[1]), 64'd0);
    chk("rst_sum", sm[1], 64'h0);
    chk("rst_cout", 64'(co[1]), 64'd0);
    rst = 1'b0;

    issue(64'h0, 64'h0, 1'b0);
    chk("calc_busy", 64'(bsy[1]), 64'd1);
    wait_done16("zero", 64'h0, 1'b0);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_done16("allones_p1_c0", 64'h0, 1'b1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    wait_done16("allones_p1_c1", 64'h1, 1'b1);

    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
    wait_done16("alt_c0", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    wait_done16("alt_c1", 64'h0, 1'b1);

    // Backpressure: result held in DONE while a new pair waits.
    issue(64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 1'b1);
    repeat (4) @(negedge clk);
    chk("bp_done", 64'(ov[1]), 64'd1);
    chk("bp_sum0", sm[1], 64'h0000_0003_0000_0001);
    hold_sum  = sm[1];
    hold_cout = co[1];
    in1 = 64'h10;
    in2 = 64'h20;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(ir[1]), 64'd0);
      chk("bp_out_valid", 64'(ov[1]), 64'd1);
      chk("bp_sum_stable", sm[1], hold_sum);
      chk("bp_cout_stable", 64'(co[1]), 64'(hold_cout));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(ir[1]), 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_new_accepted_busy", 64'(bsy[1]), 64'd1);
    chk("bp_new_accepted_ov", 64'(ov[1]), 64'd0);
    wait_done16("bp_new", 64'h30, 1'b0);

    // Reset while idx = 2.
    issue(64'h1234, 64'h4321, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 64'(ov[1]), 64'd0);
    chk("midrst_busy", 64'(bsy[1]), 64'd0);
    chk("midrst_sum", sm[1], 64'h0);
    chk("midrst_cout", 64'(co[1]), 64'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov[1]) seen = 1'b1;
    end
    chk("midrst_never_valid", 64'(seen), 64'd0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done16("max_c1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Drain every width to IDLE.
    out_ready = 1'b1;
    repeat (12) @(negedge clk);

    // Width sweep: same vectors through all four instances.
    va = '{64'h0000_0000_FFFF_FFFF, 64'h8000_0000_0000_0000,
           64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vb = '{64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000,
           64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210};
    vc = '{1'b0, 1'b1, 1'b0, 1'b1};
    vs = '{64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
    vo = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int v = 0; v < 4; v++) begin
      for (int g = 0; g < 4; g++) begin
        lat[g] = -1;
        rs[g]  = '0;
        rc[g]  = 1'b0;
      end
      issue(va[v], vb[v], vc[v]);
      for (int t = 1; t <= 12; t++) begin
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
          if (ov[g] && lat[g] < 0) begin
            lat[g] = t;
            rs[g]  = sm[g];
            rc[g]  = co[g];
          end
        end
      end
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("sweep_v%0d_w%0d_latency", v, SW[g]), 64'(lat[g]), 64'(LAT[g]));
        chk($sformatf("sweep_v%0d_w%0d_sum", v, SW[g]), rs[g], vs[v]);
        chk($sformatf("sweep_v%0d_w%0d_cout", v, SW[g]), 64'(rc[g]), 64'(vo[v]));
      end
    end

    // Continuous issue with out_ready high: spacing NSEG+1.
    p16 = '{-100, -100, -100};
    p64 = '{-100, -100, -100};
    n16 = 0;
    n64 = 0;
    in1 = 64'h5;
    in2 = 64'h7;
    cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (ov[1] && n16 < 3) begin p16[n16] = t; n16++; end
      if (ov[3] && n64 < 3) begin p64[n64] = t; n64++; end
    end
    in_valid = 1'b0;
    chk("spacing16_a", 64'(p16[1] - p16[0]), 64'd5);
    chk("spacing16_b", 64'(p16[2] - p16[1]), 64'd5);
    chk("spacing64_a", 64'(p64[1] - p64[0]), 64'd2);
    chk("spacing64_b", 64'(p64[2] - p64[1]), 64'd2);
    chk("spacing16_sum", sm[1], 64'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
